// File: rtl/wb_defs_pkg.sv
// Shared write-back definitions: MemtoReg source encodings and architectural register names.
package wb_defs_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_LINK = 2'b10,
        WB_SEL_RSV  = 2'b11
    } wb_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/wb_select_mux.sv
// Write-back source select (4:1) with detection of the reserved MemtoReg encoding.
module wb_select_mux
    import wb_defs_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] link_i,
    output logic [DATA_W-1:0] data_o,
    output logic              illegal_sel_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can
        // leave it unassigned and infer a latch.
        data_o        = alu_i;
        illegal_sel_o = 1'b0;
        case (wb_sel_e'(sel_i))
            WB_SEL_ALU:  data_o = alu_i;
            WB_SEL_MEM:  data_o = mem_i;
            WB_SEL_LINK: data_o = link_i;
            WB_SEL_RSV: begin
                // Reserved encoding falls back to the ALU result and is flagged.
                data_o        = alu_i;
                illegal_sel_o = 1'b1;
            end
            default: begin
                data_o        = alu_i;
                illegal_sel_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wb_writeback_regfile.sv
// MEM/WB consumer: write-back select, 32-entry GPR file with two read ports, forwarding export,
// retired-write counter and sticky illegal-select flag. Define WB_BYPASS_EN for write-first reads.
module wb_writeback_regfile
    import wb_defs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_RegWr,
    input  logic [1:0]        i_MemtoReg,
    input  logic [ADDR_W-1:0] i_WriteAddr,
    input  logic [DATA_W-1:0] i_ReadData,
    input  logic [DATA_W-1:0] i_ALU_result,
    input  logic [DATA_W-1:0] i_PC_next,
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic [ADDR_W-1:0] i_rt_addr,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data,
    output logic              o_wb_en,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [CNT_W-1:0]  o_wb_count,
    output logic              o_illegal
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  wb_count_q, wb_count_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] wb_data;
    logic              illegal_sel;
    logic              wb_en;

    wb_select_mux #(
        .DATA_W(DATA_W)
    ) u_select (
        .sel_i         (i_MemtoReg),
        .alu_i         (i_ALU_result),
        .mem_i         (i_ReadData),
        .link_i        (i_PC_next),
        .data_o        (wb_data),
        .illegal_sel_o (illegal_sel)
    );

    // Writes to $zero are squashed here so neither the array nor the forwarding unit sees them.
    assign wb_en = i_RegWr && (i_WriteAddr != ADDR_W'(REG_ZERO));

    assign wb_count_d = wb_count_q + CNT_W'(wb_en);
    assign illegal_d  = illegal_q | (i_RegWr & illegal_sel);

    // NOTE: the register array sits under the async reset because the architecture requires
    // every GPR to read 0 after reset; without that requirement it would be left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[i_WriteAddr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_count_q <= '0;
            illegal_q  <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            wb_count_q <= wb_count_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        o_rs_data = regs_q[i_rs_addr];
        o_rt_data = regs_q[i_rt_addr];
`ifdef WB_BYPASS_EN
        if (wb_en && (i_rs_addr == i_WriteAddr)) o_rs_data = wb_data;
        if (wb_en && (i_rt_addr == i_WriteAddr)) o_rt_data = wb_data;
`endif
        // $zero wins over both the stored value and any bypass.
        if (i_rs_addr == ADDR_W'(REG_ZERO)) o_rs_data = '0;
        if (i_rt_addr == ADDR_W'(REG_ZERO)) o_rt_data = '0;
    end

    assign o_wb_en    = wb_en;
    assign o_wb_addr  = i_WriteAddr;
    assign o_wb_data  = wb_data;
    assign o_wb_count = wb_count_q;
    assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_wb_writeback_regfile.sv
// Self-checking bench for wb_writeback_regfile: vector table plus scoreboard of committed writes.
module tb_wb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        regwr;
    logic [1:0]  memtoreg;
    logic [4:0]  waddr, rs_addr, rt_addr;
    logic [31:0] rdata, alu, pc_next;
    logic [31:0] rs_data, rt_data, wb_data, wb_count;
    logic        wb_en, illegal;
    logic [4:0]  wb_addr;

    // Narrow-counter instance, used only to observe counter wrap.
    logic [31:0] n_rs_data, n_rt_data, n_wb_data;
    logic        n_wb_en, n_illegal;
    logic [4:0]  n_wb_addr;
    logic [1:0]  n_wb_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_writeback_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .i_RegWr(regwr), .i_MemtoReg(memtoreg),
        .i_WriteAddr(waddr), .i_ReadData(rdata), .i_ALU_result(alu), .i_PC_next(pc_next),
        .i_rs_addr(rs_addr), .i_rt_addr(rt_addr), .o_rs_data(rs_data), .o_rt_data(rt_data),
        .o_wb_en(wb_en), .o_wb_addr(wb_addr), .o_wb_data(wb_data), .o_wb_count(wb_count),
        .o_illegal(illegal)
    );

    wb_writeback_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut_narrow (
        .clk(clk), .reset(reset), .i_RegWr(regwr), .i_MemtoReg(memtoreg),
        .i_WriteAddr(waddr), .i_ReadData(rdata), .i_ALU_result(alu), .i_PC_next(pc_next),
        .i_rs_addr(rs_addr), .i_rt_addr(rt_addr), .o_rs_data(n_rs_data), .o_rt_data(n_rt_data),
        .o_wb_en(n_wb_en), .o_wb_addr(n_wb_addr), .o_wb_data(n_wb_data), .o_wb_count(n_wb_count),
        .o_illegal(n_illegal)
    );

    typedef struct {
        logic        regwr;
        logic [1:0]  sel;
        logic [4:0]  addr;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] pc;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } commit_t;

    commit_t     sb[$];
    vec_t        vecs[10];
    logic [31:0] mdl_regs [32];
    logic [31:0] mdl_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic check_counters(input string tag, input logic exp_illegal);
        check({tag, " count"}, wb_count, mdl_cnt);
        check({tag, " count_wrap"}, {30'd0, n_wb_count}, mdl_cnt & 32'd3);
        check({tag, " illegal"}, {31'd0, illegal}, {31'd0, exp_illegal});
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        commit_t c;
        @(negedge clk);
        regwr = v.regwr; memtoreg = v.sel; waddr = v.addr;
        rdata = v.rdata; alu = v.alu; pc_next = v.pc;
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        check($sformatf("v%0d wb_en", idx), {31'd0, wb_en}, {31'd0, v.exp_en});
        check($sformatf("v%0d wb_addr", idx), {27'd0, wb_addr}, {27'd0, v.addr});
        check($sformatf("v%0d wb_data", idx), wb_data, v.exp_data);
        if (v.exp_en) begin
            mdl_regs[v.addr] = v.exp_data;
            mdl_cnt++;
        end
        c.addr = v.addr;
        c.data = mdl_regs[v.addr];
        sb.push_back(c);
        @(posedge clk);
        #1;
        regwr = 1'b0;
        c = sb.pop_front();
        rs_addr = c.addr;
        rt_addr = c.addr;
        #1;
        check($sformatf("v%0d rs r%0d", idx, c.addr), rs_data, c.data);
        check($sformatf("v%0d rt r%0d", idx, c.addr), rt_data, c.data);
        check_counters($sformatf("v%0d", idx), 1'b0);
    endtask

    initial begin
        //          regwr sel    addr   rdata         alu           pc            en    data
        vecs[0] = '{1'b1, 2'b00, 5'd8,  32'h0,        32'h1234_5678, 32'h0,        1'b1, 32'h1234_5678};
        vecs[1] = '{1'b1, 2'b01, 5'd31, 32'hDEAD_BEEF, 32'h1111_0000, 32'h0,       1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 2'b10, 5'd31, 32'h0,        32'h2222_0000, 32'h0040_0008, 1'b1, 32'h0040_0008};
        vecs[3] = '{1'b1, 2'b00, 5'd0,  32'h0,        32'hFFFF_FFFF, 32'h0,        1'b0, 32'hFFFF_FFFF};
        vecs[4] = '{1'b0, 2'b01, 5'd5,  32'h1111_2222, 32'h0,        32'h0,        1'b0, 32'h1111_2222};
        vecs[5] = '{1'b1, 2'b01, 5'd5,  32'h3333_4444, 32'h5555_6666, 32'h7777_8888, 1'b1, 32'h3333_4444};
        vecs[6] = '{1'b1, 2'b10, 5'd1,  32'hAAAA_0000, 32'hBBBB_0000, 32'h0000_0100, 1'b1, 32'h0000_0100};
        vecs[7] = '{1'b1, 2'b00, 5'd8,  32'hCCCC_0000, 32'h8000_0001, 32'hDDDD_0000, 1'b1, 32'h8000_0001};
        vecs[8] = '{1'b1, 2'b01, 5'd0,  32'h0BAD_F00D, 32'h0,        32'h0,        1'b0, 32'h0BAD_F00D};
        vecs[9] = '{1'b1, 2'b00, 5'd30, 32'h0,        32'hCAFE_0030, 32'h0,        1'b1, 32'hCAFE_0030};

        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
        mdl_cnt = 32'h0;

        reset = 1'b0; regwr = 1'b0; memtoreg = 2'b00; waddr = 5'd0;
        rdata = 32'h0; alu = 32'h0; pc_next = 32'h0; rs_addr = 5'd0; rt_addr = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Every register reads zero out of reset, on both ports.
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            check($sformatf("reset rs r%0d", i), rs_data, 32'h0);
            check($sformatf("reset rt r%0d", 31 - i), rt_data, 32'h0);
        end
        check_counters("reset", 1'b0);

        for (int i = 0; i < 10; i++) apply_vec(i, vecs[i]);

        // Same-cycle write and read of r9: bypass build sees the new value immediately.
        @(negedge clk);
        regwr = 1'b1; memtoreg = 2'b00; waddr = 5'd9; alu = 32'hA5A5_A5A5;
        rs_addr = 5'd9; rt_addr = 5'd9;
        #1;
`ifdef WB_BYPASS_EN
        check("same-cycle rs r9", rs_data, 32'hA5A5_A5A5);
        check("same-cycle rt r9", rt_data, 32'hA5A5_A5A5);
`else
        check("same-cycle rs r9", rs_data, mdl_regs[9]);
        check("same-cycle rt r9", rt_data, mdl_regs[9]);
`endif
        mdl_regs[9] = 32'hA5A5_A5A5;
        mdl_cnt++;
        @(posedge clk);
        #1;
        regwr = 1'b0;
        #1;
        check("next-cycle rs r9", rs_data, 32'hA5A5_A5A5);
        check("next-cycle rt r9", rt_data, 32'hA5A5_A5A5);

        // A write aimed at $zero must not leak through a read of r0, bypass or not.
        @(negedge clk);
        regwr = 1'b1; waddr = 5'd0; alu = 32'hFFFF_FFFF; rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        check("zero-write rs r0", rs_data, 32'h0);
        check("zero-write wb_en", {31'd0, wb_en}, 32'h0);
        @(posedge clk);
        #1;
        regwr = 1'b0;
        check_counters("zero-write", 1'b0);

        // Reserved select without RegWr leaves the flag clear and the register untouched.
        @(negedge clk);
        regwr = 1'b0; memtoreg = 2'b11; waddr = 5'd12; alu = 32'h0000_0003;
        @(posedge clk);
        #1;
        rs_addr = 5'd12;
        #1;
        check("rsv no-wr r12", rs_data, 32'h0);
        check_counters("rsv no-wr", 1'b0);

        // Reserved select with RegWr: ALU fallback is written and the flag becomes sticky.
        @(negedge clk);
        regwr = 1'b1; memtoreg = 2'b11; waddr = 5'd12; alu = 32'h0000_0007; rs_addr = 5'd0;
        #1;
        check("rsv wb_data", wb_data, 32'h0000_0007);
        check("rsv illegal pre-edge", {31'd0, illegal}, 32'h0);
        mdl_regs[12] = 32'h7;
        mdl_cnt++;
        @(posedge clk);
        #1;
        regwr = 1'b0; memtoreg = 2'b00; rs_addr = 5'd12;
        #1;
        check("rsv r12", rs_data, 32'h0000_0007);
        check_counters("rsv wr", 1'b1);
        @(negedge clk);
        regwr = 1'b1; memtoreg = 2'b01; waddr = 5'd13; rdata = 32'h0000_1313;
        mdl_regs[13] = 32'h1313;
        mdl_cnt++;
        @(posedge clk);
        #1;
        regwr = 1'b0;
        check_counters("sticky", 1'b1);

        // Reset asserted mid-cycle with a write pending: the write is lost and state cleared.
        @(negedge clk);
        regwr = 1'b1; memtoreg = 2'b00; waddr = 5'd14; alu = 32'h0000_5555;
        #2;
        reset = 1'b0;
        regwr = 1'b0;
        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
        mdl_cnt = 32'h0;
        #1;
        rs_addr = 5'd12; rt_addr = 5'd13;
        #1;
        check("mid-reset r12", rs_data, 32'h0);
        check("mid-reset r13", rt_data, 32'h0);
        check_counters("mid-reset", 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        rs_addr = 5'd14; rt_addr = 5'd31;
        #1;
        check("post-reset r14", rs_data, 32'h0);
        check("post-reset r31", rt_data, 32'h0);
        check_counters("post-reset", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
